// File: rtl/alu_writeback.sv
// Writeback/flag stage behind the ALU: registers results, owns C/V/Z/S, stretches multi-cycle ops.
// Optional operand-forwarding outputs are enabled with `define WB_BYPASS_EN.
module alu_writeback #(
   parameter int unsigned MCP_CYCLES = 2,
   parameter int unsigned RADDR_W    = 4
) (
   input  logic               clk,
   input  logic               reset_b,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [5:0]         opcode,
   input  logic [RADDR_W-1:0] rdest,
   input  logic [31:0]        alu_dout,
   input  logic               alu_cout,
   input  logic               alu_vout,
   input  logic               alu_qnzout,
   input  logic               alu_mcp,
   output logic               wr_en,
   output logic [RADDR_W-1:0] wr_addr,
   output logic [31:0]        wr_data,
   output logic               flag_c,
   output logic               flag_v,
   output logic               flag_z,
   output logic               flag_s,
   output logic               djnz_taken,
   output logic               byp_valid,
   output logic [RADDR_W-1:0] byp_addr,
   output logic [31:0]        byp_data
);

   // Opcode encodings shared with the ALU.
   localparam logic [5:0] OpMov   = 6'h00;
   localparam logic [5:0] OpLmov  = 6'h01;
   localparam logic [5:0] OpLmovt = 6'h02;
   localparam logic [5:0] OpAdd   = 6'h04;
   localparam logic [5:0] OpSub   = 6'h05;
   localparam logic [5:0] OpCmp   = 6'h06;
   localparam logic [5:0] OpNeg   = 6'h07;
   localparam logic [5:0] OpMul   = 6'h08;
   localparam logic [5:0] OpAnd   = 6'h0C;
   localparam logic [5:0] OpOr    = 6'h0D;
   localparam logic [5:0] OpXor   = 6'h0E;
   localparam logic [5:0] OpAsl   = 6'h10;
   localparam logic [5:0] OpAsr   = 6'h11;
   localparam logic [5:0] OpLsr   = 6'h12;
   localparam logic [5:0] OpRol   = 6'h13;
   localparam logic [5:0] OpRor   = 6'h14;
   localparam logic [5:0] OpBtst  = 6'h18;
   localparam logic [5:0] OpBset  = 6'h19;
   localparam logic [5:0] OpBclr  = 6'h1A;
   localparam logic [5:0] OpDjnz  = 6'h20;

   localparam int unsigned CntW = (MCP_CYCLES > 2) ? $clog2(MCP_CYCLES) : 1;
   localparam logic [CntW-1:0] CntLoad = CntW'(MCP_CYCLES - 2);

   typedef enum logic [0:0] {StIdle, StMcpWait} state_e;

   state_e              state_q, state_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic                wr_en_q, wr_en_d;
   logic [RADDR_W-1:0]  wr_addr_q, wr_addr_d;
   logic [31:0]         wr_data_q, wr_data_d;
   logic                flag_c_q, flag_c_d, flag_v_q, flag_v_d;
   logic                flag_z_q, flag_z_d, flag_s_q, flag_s_d;
   logic                djnz_q, djnz_d;
   logic                capture;
   logic                flag_op;
   logic                no_write_op;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      capture = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               if (alu_mcp) begin
                  cnt_d   = CntLoad;
                  state_d = StMcpWait;
               end else begin
                  capture = 1'b1;
               end
            end
         end
         StMcpWait: begin
            // in_valid is not consulted here: issue holds the op until we return to idle.
            if (cnt_q == '0) begin
               capture = 1'b1;
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      flag_op     = 1'b0;
      no_write_op = 1'b0;
      case (opcode)
         OpAdd, OpSub, OpNeg, OpMul, OpAnd, OpOr, OpXor,
         OpAsl, OpAsr, OpLsr, OpRol, OpRor:            flag_op = 1'b1;
         OpCmp, OpBtst: begin
            flag_op     = 1'b1;
            no_write_op = 1'b1;
         end
         OpMov, OpLmov, OpLmovt, OpBset, OpBclr, OpDjnz: flag_op = 1'b0;
         default:                                        flag_op = 1'b0;
      endcase
   end

   always_comb begin
      wr_en_d   = capture && !no_write_op;
      wr_addr_d = capture ? rdest : wr_addr_q;
      wr_data_d = capture ? alu_dout : wr_data_q;
      djnz_d    = capture && (opcode == OpDjnz) && alu_qnzout;
      flag_c_d  = flag_c_q;
      flag_v_d  = flag_v_q;
      flag_z_d  = flag_z_q;
      flag_s_d  = flag_s_q;
      if (capture && flag_op) begin
         flag_c_d = alu_cout;
         flag_v_d = alu_vout;
         flag_z_d = (alu_dout == 32'h0);
         flag_s_d = alu_dout[31];
      end
   end

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         flag_c_q  <= 1'b0;
         flag_v_q  <= 1'b0;
         flag_z_q  <= 1'b0;
         flag_s_q  <= 1'b0;
         djnz_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         flag_c_q  <= flag_c_d;
         flag_v_q  <= flag_v_d;
         flag_z_q  <= flag_z_d;
         flag_s_q  <= flag_s_d;
         djnz_q    <= djnz_d;
      end
   end

   assign in_ready   = reset_b && (state_q == StIdle);
   assign wr_en      = wr_en_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign flag_c     = flag_c_q;
   assign flag_v     = flag_v_q;
   assign flag_z     = flag_z_q;
   assign flag_s     = flag_s_q;
   assign djnz_taken = djnz_q;

`ifdef WB_BYPASS_EN
   assign byp_valid = wr_en_q;
   assign byp_addr  = wr_addr_q;
   assign byp_data  = wr_data_q;
`else
   assign byp_valid = 1'b0;
   assign byp_addr  = '0;
   assign byp_data  = '0;
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// Directed self-checking bench for alu_writeback (MCP_CYCLES=3, default build without bypass).
module tb_alu_writeback;

   localparam logic [5:0] OpMov  = 6'h00;
   localparam logic [5:0] OpAdd  = 6'h04;
   localparam logic [5:0] OpSub  = 6'h05;
   localparam logic [5:0] OpCmp  = 6'h06;
   localparam logic [5:0] OpMul  = 6'h08;
   localparam logic [5:0] OpDjnz = 6'h20;
   localparam logic [5:0] OpBad  = 6'h3F;

   logic        clk = 1'b0;
   logic        reset_b;
   logic        in_valid;
   logic        in_ready;
   logic [5:0]  opcode;
   logic [3:0]  rdest;
   logic [31:0] alu_dout;
   logic        alu_cout, alu_vout, alu_qnzout, alu_mcp;
   logic        wr_en;
   logic [3:0]  wr_addr;
   logic [31:0] wr_data;
   logic        flag_c, flag_v, flag_z, flag_s;
   logic        djnz_taken;
   logic        byp_valid;
   logic [3:0]  byp_addr;
   logic [31:0] byp_data;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   alu_writeback #(
      .MCP_CYCLES (3),
      .RADDR_W    (4)
   ) dut (
      .clk        (clk),
      .reset_b    (reset_b),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .opcode     (opcode),
      .rdest      (rdest),
      .alu_dout   (alu_dout),
      .alu_cout   (alu_cout),
      .alu_vout   (alu_vout),
      .alu_qnzout (alu_qnzout),
      .alu_mcp    (alu_mcp),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .flag_c     (flag_c),
      .flag_v     (flag_v),
      .flag_z     (flag_z),
      .flag_s     (flag_s),
      .djnz_taken (djnz_taken),
      .byp_valid  (byp_valid),
      .byp_addr   (byp_addr),
      .byp_data   (byp_data)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [5:0] op, input logic [3:0] rd,
                        input logic [31:0] d, input logic c, input logic ov,
                        input logic qnz, input logic mcp);
      in_valid   = v;
      opcode     = op;
      rdest      = rd;
      alu_dout   = d;
      alu_cout   = c;
      alu_vout   = ov;
      alu_qnzout = qnz;
      alu_mcp    = mcp;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Flags packed as {C,V,Z,S}.
   task automatic check_flags(input string tag, input logic [3:0] exp);
      check_eq(tag, 32'({flag_c, flag_v, flag_z, flag_s}), 32'(exp));
   endtask

   task automatic check_zero_outputs(input string tag);
      check_eq({tag, "_wr_en"},   32'(wr_en), 32'd0);
      check_eq({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
      check_eq({tag, "_wr_data"}, wr_data, 32'd0);
      check_flags({tag, "_flags"}, 4'b0000);
      check_eq({tag, "_djnz"},    32'(djnz_taken), 32'd0);
      check_eq({tag, "_byp"},     32'({byp_valid, byp_addr}) | byp_data, 32'd0);
   endtask

   initial begin
      reset_b = 1'b0;
      drive(1'b0, OpMov, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (2) step();
      check_zero_outputs("reset");
      reset_b = 1'b1;
      #1;
      check_eq("ready_after_reset", 32'(in_ready), 32'd1);

      // ADD r3, result 0 with carry.
      drive(1'b1, OpAdd, 4'd3, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      check_eq("add_wr_en", 32'(wr_en), 32'd1);
      check_eq("add_wr_addr", 32'(wr_addr), 32'd3);
      check_eq("add_wr_data", wr_data, 32'h0);
      check_flags("add_flags", 4'b1010);

      // CMP: flags only, no write; MOV follows back-to-back.
      drive(1'b1, OpCmp, 4'd7, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      check_eq("cmp_wr_en", 32'(wr_en), 32'd0);
      check_flags("cmp_flags", 4'b0001);
      drive(1'b1, OpMov, 4'd2, 32'd5, 1'b1, 1'b1, 1'b0, 1'b0);
      step();
      check_eq("mov_wr_en", 32'(wr_en), 32'd1);
      check_eq("mov_wr_addr", 32'(wr_addr), 32'd2);
      check_eq("mov_wr_data", wr_data, 32'd5);
      check_flags("mov_flags", 4'b0001);

      // Idle cycle: no write, data held.
      drive(1'b0, OpAdd, 4'd9, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0, 1'b0);
      step();
      check_eq("idle_wr_en", 32'(wr_en), 32'd0);
      check_eq("idle_wr_data", wr_data, 32'd5);
      check_flags("idle_flags", 4'b0001);

      // SUB giving all-ones: sign set, zero clear.
      drive(1'b1, OpSub, 4'd6, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0);
      step();
      check_eq("sub_wr_data", wr_data, 32'hFFFF_FFFF);
      check_flags("sub_flags", 4'b0101);

      // Unknown opcode writes but leaves flags alone.
      drive(1'b1, OpBad, 4'd8, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      check_eq("bad_wr_en", 32'(wr_en), 32'd1);
      check_flags("bad_flags", 4'b0101);

      // MUL r4, 3-cycle op: two stall cycles then a single write.
      drive(1'b1, OpMul, 4'd4, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 1'b1);
      step();
      check_eq("mul_c1_ready", 32'(in_ready), 32'd0);
      check_eq("mul_c1_wr_en", 32'(wr_en), 32'd0);
      step();
      check_eq("mul_c2_ready", 32'(in_ready), 32'd0);
      check_eq("mul_c2_wr_en", 32'(wr_en), 32'd0);
      step();
      check_eq("mul_c3_ready", 32'(in_ready), 32'd1);
      check_eq("mul_c3_wr_en", 32'(wr_en), 32'd1);
      check_eq("mul_wr_addr", 32'(wr_addr), 32'd4);
      check_eq("mul_wr_data", wr_data, 32'h1234_5678);
      check_flags("mul_flags", 4'b0100);
      drive(1'b0, OpMul, 4'd4, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 1'b1);
      step();
      check_eq("mul_no_double", 32'(wr_en), 32'd0);

      // DJNZ r1: taken then not taken; flags untouched.
      drive(1'b1, OpDjnz, 4'd1, 32'd9, 1'b1, 1'b0, 1'b1, 1'b0);
      step();
      check_eq("djnz1_taken", 32'(djnz_taken), 32'd1);
      check_eq("djnz1_wr_en", 32'(wr_en), 32'd1);
      check_eq("djnz1_wr_addr", 32'(wr_addr), 32'd1);
      check_eq("djnz1_wr_data", wr_data, 32'd9);
      drive(1'b1, OpDjnz, 4'd1, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      check_eq("djnz0_taken", 32'(djnz_taken), 32'd0);
      check_eq("djnz0_wr_en", 32'(wr_en), 32'd1);
      check_eq("djnz0_wr_addr", 32'(wr_addr), 32'd1);
      check_eq("djnz0_wr_data", wr_data, 32'd0);
      check_flags("djnz_flags", 4'b0100);

      // Reset in the middle of a multi-cycle wait.
      drive(1'b1, OpMul, 4'd5, 32'hCAFE_0001, 1'b1, 1'b1, 1'b0, 1'b1);
      step();
      check_eq("mcprst_ready", 32'(in_ready), 32'd0);
      #2;
      reset_b = 1'b0;
      #1;
      check_zero_outputs("mcprst");
      drive(1'b0, OpMov, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      reset_b = 1'b1;
      #1;
      check_eq("mcprst_ready_rel", 32'(in_ready), 32'd1);
      repeat (3) begin
         step();
         check_eq("mcprst_no_write", 32'(wr_en), 32'd0);
         check_eq("mcprst_idle", 32'(in_ready), 32'd1);
      end
      check_zero_outputs("mcprst_after");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
